// File: rtl/qam_pkg.sv
// Shared QAM types and sizing helpers for qam_mapper and constellation_former.
package qam_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam int unsigned QAM_IP = 5;

  typedef struct packed {
    logic signed [QAM_IP-1:0] i;
    logic signed [QAM_IP-1:0] q;
  } iq_point_t;

  function automatic int unsigned bps_f(input int unsigned points);
    return $clog2(points);
  endfunction

  function automatic int unsigned buf_w_f(input int unsigned in_w, input int unsigned points);
    return in_w + $clog2(points);
  endfunction

endpackage

// File: rtl/qam_bit_gearbox.sv
// Regroups IN_WIDTH-bit words into BPS-bit symbol indices, MSB first, zero-padding the tail on flush.
// QAM_MAPPER_STATS_EN adds a padded-symbol counter output.
module qam_bit_gearbox
  import qam_pkg::*;
#(
  parameter int unsigned POINTS   = 128,
  parameter int unsigned IN_WIDTH = 8,
  localparam int unsigned BPS     = bps_f(POINTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic [IN_WIDTH-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                s_accept_o,
  output logic [BPS-1:0]      idx_o,
  output logic                idx_valid_o,
  output logic                idx_last_o,
  input  logic                idx_ready_i
`ifdef QAM_MAPPER_STATS_EN
  ,
  output logic [31:0]         pad_count_o
`endif
);

  localparam int unsigned BUF_W  = buf_w_f(IN_WIDTH, POINTS);
  localparam int unsigned FILL_W = $clog2(BUF_W + 1);
  localparam logic [FILL_W-1:0] BPS_F   = FILL_W'(BPS);
  localparam logic [FILL_W-1:0] IN_F    = FILL_W'(IN_WIDTH);
  localparam logic [FILL_W-1:0] ACC_MAX = FILL_W'(BUF_W - IN_WIDTH);

  // Valid bits sit left-aligned in buf_q; everything below fill_q is kept zero.
  logic [BUF_W-1:0]  buf_q, buf_d, buf_shift;
  logic [FILL_W-1:0] fill_q, fill_d, fill_shift;
  logic              live_q;
  logic              whole, pad, emit, accept;

  assign s_ready     = live_q && !flush_i && (fill_q <= ACC_MAX);
  assign accept      = s_valid && s_ready;
  assign s_accept_o  = accept;

  assign whole       = fill_q >= BPS_F;
  assign pad         = flush_i && (fill_q != '0) && !whole;
  assign idx_valid_o = whole || pad;
  assign idx_last_o  = flush_i && (pad || (fill_q == BPS_F));
  assign idx_o       = buf_q[BUF_W-1 -: BPS];
  assign emit        = idx_valid_o && idx_ready_i;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    buf_shift  = buf_q;
    fill_shift = fill_q;
    if (emit) begin
      buf_shift  = buf_q << BPS;
      fill_shift = pad ? '0 : (fill_q - BPS_F);
    end
    buf_d  = buf_shift;
    fill_d = fill_shift;
    if (accept) begin
      buf_d  = buf_shift | (BUF_W'(s_data) << (ACC_MAX - fill_shift));
      fill_d = fill_shift + IN_F;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      fill_q <= '0;
      live_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      live_q <= 1'b1;
    end
  end

`ifdef QAM_MAPPER_STATS_EN
  logic [31:0] pad_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_count_q <= '0;
    end else if (emit && pad) begin
      pad_count_q <= pad_count_q + 32'd1;
    end
  end

  assign pad_count_o = pad_count_q;
`endif

endmodule

// File: rtl/qam_mapper.sv
// Streaming QAM mapper: bit gearbox, packet FSM and registered constellation lookup.
// Define QAM_MAPPER_STATS_EN to add the sym_count/pad_count statistics outputs.
module qam_mapper
  import qam_pkg::*;
#(
  parameter int unsigned POINTS       = 128,
  parameter int unsigned INTEGER_PART = 5,
  parameter int unsigned IN_WIDTH     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [2*INTEGER_PART-1:0]      constellation_points [POINTS],
  input  logic [IN_WIDTH-1:0]            s_data,
  input  logic                           s_valid,
  input  logic                           s_last,
  output logic                           s_ready,
  output logic signed [INTEGER_PART-1:0] m_i,
  output logic signed [INTEGER_PART-1:0] m_q,
  output logic                           m_valid,
  output logic                           m_last,
  input  logic                           m_ready
`ifdef QAM_MAPPER_STATS_EN
  ,
  output logic [31:0]                    sym_count,
  output logic [31:0]                    pad_count
`endif
);

  localparam int unsigned BPS = bps_f(POINTS);

  state_e                        state_q, state_d;
  logic [BPS-1:0]                idx;
  logic                          idx_valid, idx_last, idx_ready, s_accept, emit;
  logic [2*INTEGER_PART-1:0]     point;
  logic signed [INTEGER_PART-1:0] m_i_q, m_i_d, m_q_q, m_q_d;
  logic                          m_valid_q, m_valid_d, m_last_q, m_last_d;

  // Gearbox may hand over a symbol whenever the output register is empty or draining.
  assign idx_ready = !m_valid_q || m_ready;
  assign emit      = idx_valid && idx_ready;
  assign point     = constellation_points[idx];

  qam_bit_gearbox #(
    .POINTS   (POINTS),
    .IN_WIDTH (IN_WIDTH)
  ) u_gearbox (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (state_q == ST_FLUSH),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_accept_o  (s_accept),
    .idx_o       (idx),
    .idx_valid_o (idx_valid),
    .idx_last_o  (idx_last),
    .idx_ready_i (idx_ready)
`ifdef QAM_MAPPER_STATS_EN
    ,
    .pad_count_o (pad_count)
`endif
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL:  if (s_accept && s_last) state_d = ST_FLUSH;
      ST_FLUSH: if (emit && idx_last)   state_d = ST_FILL;
      default:  state_d = ST_FILL;
    endcase
  end

  always_comb begin
    m_i_d     = m_i_q;
    m_q_d     = m_q_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q && !m_ready;
    if (emit) begin
      m_i_d     = point[2*INTEGER_PART-1:INTEGER_PART];
      m_q_d     = point[INTEGER_PART-1:0];
      m_last_d  = idx_last;
      m_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      m_i_q     <= '0;
      m_q_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_i_q     <= m_i_d;
      m_q_q     <= m_q_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_i     = m_i_q;
  assign m_q     = m_q_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

`ifdef QAM_MAPPER_STATS_EN
  logic [31:0] sym_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_count_q <= '0;
    end else if (m_valid_q && m_ready) begin
      sym_count_q <= sym_count_q + 32'd1;
    end
  end

  assign sym_count = sym_count_q;
`endif

endmodule

// File: tb/tb_qam_mapper.sv
// Directed bench for qam_mapper (POINTS=128, INTEGER_PART=5, IN_WIDTH=8); covers QAM_MAPPER_STATS_EN when defined.
module tb_qam_mapper;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [9:0]        pts [128];
  logic [7:0]        s_data;
  logic              s_valid, s_last, s_ready;
  logic signed [4:0] m_i, m_q;
  logic              m_valid, m_last, m_ready;
`ifdef QAM_MAPPER_STATS_EN
  logic [31:0]       sym_count, pad_count;
`endif

  always #5 clk = ~clk;

  qam_mapper #(
    .POINTS       (128),
    .INTEGER_PART (5),
    .IN_WIDTH     (8)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .constellation_points (pts),
    .s_data               (s_data),
    .s_valid              (s_valid),
    .s_last               (s_last),
    .s_ready              (s_ready),
    .m_i                  (m_i),
    .m_q                  (m_q),
    .m_valid              (m_valid),
    .m_last               (m_last),
    .m_ready              (m_ready)
`ifdef QAM_MAPPER_STATS_EN
    ,
    .sym_count            (sym_count),
    .pad_count            (pad_count)
`endif
  );

  // One packet: words packed first-word-in-MSBs, expected symbol indices likewise.
  typedef struct {
    string       name;
    int          n_words;
    logic [63:0] words;
    int          n_syms;
    logic [62:0] syms;
  } vec_t;

  typedef struct packed {
    logic [6:0] idx;
    logic       last;
  } exp_t;

  vec_t vecs [5];
  exp_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t mon_e;
  logic [9:0] mon_pt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard: every handshake is compared against the next expected symbol.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_symbol: got i=%0h q=%0h expected no symbol", m_i, m_q);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_pt = pts[mon_e.idx];
        check($sformatf("m_i idx=%0h", mon_e.idx), 32'($unsigned(m_i)), 32'(mon_pt[9:5]));
        check($sformatf("m_q idx=%0h", mon_e.idx), 32'($unsigned(m_q)), 32'(mon_pt[4:0]));
        check($sformatf("m_last idx=%0h", mon_e.idx), 32'(m_last), 32'(mon_e.last));
      end
    end
  end

  task automatic send_word(input logic [7:0] data, input logic last);
    int n;
    s_data  = data;
    s_last  = last;
    s_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 200) begin
        check("s_ready_timeout", 32'(s_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic push_expect(input int v);
    logic [62:0] s;
    s = vecs[v].syms;
    for (int k = 0; k < vecs[v].n_syms; k++)
      exp_q.push_back('{idx: s[62-7*k -: 7], last: (k == vecs[v].n_syms - 1)});
  endtask

  task automatic send_packet(input int v);
    logic [63:0] w;
    w = vecs[v].words;
    for (int k = 0; k < vecs[v].n_words; k++)
      send_word(w[63-8*k -: 8], k == vecs[v].n_words - 1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic signed [4:0] snap_i, snap_q;
    int n;

    for (int k = 0; k < 128; k++) pts[k] = 10'(k * 7 + 3);
    vecs[0] = '{"one_word_pad", 1, 64'hA5 << 56, 2, {7'h52, 7'h40, 49'd0}};
    vecs[1] = '{"seven_words", 7, {56'h02081840A18388, 8'h00}, 8,
                {7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08, 7'h00}};
    vecs[2] = '{"zero_pad", 2, {16'hFF00, 48'd0}, 3, {7'h7F, 7'h40, 7'h00, 42'd0}};
    vecs[3] = '{"all_ones", 7, {56'hFFFFFFFFFFFFFF, 8'h00}, 8,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00}};
    vecs[4] = '{"three_words", 3, {24'h123456, 40'd0}, 4, {7'h09, 7'h0D, 7'h0A, 7'h60, 35'd0}};

    // Reset with s_valid asserted
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hFF;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_i", 32'($unsigned(m_i)), 32'd0);
    check("rst_m_q", 32'($unsigned(m_q)), 32'd0);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    #1;
    check("release_s_ready_same_cycle", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    check("release_s_ready_next_cycle", 32'(s_ready), 32'd1);

    // Single-byte packet with pad, then 56-bit packet without pad
    for (int v = 0; v < 2; v++) begin
      push_expect(v);
      send_packet(v);
      wait_drain(vecs[v].name);
    end
`ifdef QAM_MAPPER_STATS_EN
    check("sym_count", sym_count, 32'd10);
    check("pad_count", pad_count, 32'd1);
`endif

    for (int v = 2; v < 5; v++) begin
      push_expect(v);
      send_packet(v);
      wait_drain(vecs[v].name);
    end

    // Downstream stall mid-packet
    push_expect(1);
    fork
      send_packet(1);
      begin
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!m_valid && n < 50);
        check("stall_m_valid_seen", 32'(m_valid), 32'd1);
        m_ready = 1'b0;
        snap_i  = m_i;
        snap_q  = m_q;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("stall_m_valid", 32'(m_valid), 32'd1);
          check("stall_m_i", 32'($unsigned(m_i)), 32'($unsigned(snap_i)));
          check("stall_m_q", 32'($unsigned(m_q)), 32'($unsigned(snap_q)));
        end
        check("stall_s_ready_low", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_drain("stall");

    // Back-to-back packets must not share a symbol
    push_expect(0);
    push_expect(0);
    send_packet(0);
    send_packet(0);
    wait_drain("back_to_back");

    // Reset mid-packet discards the partial buffer
    exp_q.push_back('{idx: 7'h01, last: 1'b0});
    exp_q.push_back('{idx: 7'h02, last: 1'b0});
    exp_q.push_back('{idx: 7'h03, last: 1'b0});
    send_word(8'h02, 1'b0);
    send_word(8'h08, 1'b0);
    send_word(8'h18, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_syms", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_last", 32'(m_last), 32'd0);
    check("midrst_m_i", 32'($unsigned(m_i)), 32'd0);
    check("midrst_m_q", 32'($unsigned(m_q)), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_expect(0);
    send_packet(0);
    wait_drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
